// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the decode-stage hazard controller.
package hazard_ctrl_pkg;

    localparam int NREG   = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 3;
    localparam int FCNT_W = 2;

    typedef enum logic [1:0] {HZ_RUN, HZ_DRAIN, HZ_FLUSH} hz_state_t;

    typedef struct packed {
        logic issue;
        logic stall;
        logic flush;
    } hz2dec_pkt_t;

    function automatic logic [NREG-1:0] reg_onehot(input logic [REG_W-1:0] r);
        logic [NREG-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Pending-load destination scoreboard; read ports see a same-cycle writeback as already released.
module hazard_ctrl_scoreboard
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_rd,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [REG_W-1:0] rd,
    output logic [NREG-1:0]  busy,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             rd_busy
);

    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] eff_busy;

    // x0 can never be marked or cleared, so it never hazards
    assign clr_vec  = clr_en ? (reg_onehot(clr_rd) & ~NREG'(1)) : '0;
    assign set_vec  = (set_en && set_rd != '0) ? reg_onehot(set_rd) : '0;
    assign eff_busy = busy & ~clr_vec;

    assign rs1_busy = eff_busy[rs1];
    assign rs2_busy = eff_busy[rs2];
    assign rd_busy  = eff_busy[rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= eff_busy | set_vec;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: issue/stall/flush decision, load counting and fence drain.
//   state    | meaning
//   HZ_RUN   | normal issue; loads-only RAW/WAW stalls, load-limit stall
//   HZ_DRAIN | fence held in decode until all outstanding loads write back
//   HZ_FLUSH | post-redirect window, decode contents invalidated
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MAX_LD    = 2,
    parameter int FLUSH_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid_i,
    input  logic [REG_W-1:0] dec_rs1_i,
    input  logic             dec_use_rs1_i,
    input  logic [REG_W-1:0] dec_rs2_i,
    input  logic             dec_use_rs2_i,
    input  logic [REG_W-1:0] dec_rd_i,
    input  logic             dec_is_load_i,
    input  logic             dec_fence_i,
    input  logic             ld_done_i,
    input  logic [REG_W-1:0] ld_done_rd_i,
    input  logic             redirect_i,
    output logic             issue_o,
    output logic             stall_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] ld_cnt_o,
    output logic [NREG-1:0]  busy_o,
    output logic             err_o
);

    hz_state_t         state;
    hz_state_t         state_nxt;
    hz2dec_pkt_t       ctl;
    logic [FCNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0]  ld_cnt_eff;
    logic              ld_dec;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              rd_busy;
    logic              raw;
    logic              ld_full;
    logic              fence_wait;

    hazard_ctrl_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (ctl.issue & dec_is_load_i),
        .set_rd   (dec_rd_i),
        .clr_en   (ld_done_i),
        .clr_rd   (ld_done_rd_i),
        .rs1      (dec_rs1_i),
        .rs2      (dec_rs2_i),
        .rd       (dec_rd_i),
        .busy     (busy_o),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );

    // a spurious writeback with nothing outstanding must not wrap the counter
    assign ld_dec     = ld_done_i & (ld_cnt_o != '0);
    assign ld_cnt_eff = ld_cnt_o - CNT_W'(ld_dec);
    assign raw        = (dec_use_rs1_i & rs1_busy) | (dec_use_rs2_i & rs2_busy) | rd_busy;
    assign ld_full    = dec_is_load_i & (ld_cnt_eff == CNT_W'(MAX_LD));
    assign fence_wait = dec_fence_i & (ld_cnt_eff != '0);

    always_comb begin
        ctl       = '0;
        state_nxt = state;
        if (rst) begin
            state_nxt = HZ_RUN;
        end else if (redirect_i) begin
            ctl.flush = 1'b1;
            state_nxt = (FLUSH_CYC > 1) ? HZ_FLUSH : HZ_RUN;
        end else begin
            case (state)
                HZ_RUN: begin
                    ctl.issue = dec_valid_i & ~raw & ~ld_full & ~fence_wait;
                    ctl.stall = dec_valid_i & ~ctl.issue;
                    if (dec_valid_i && fence_wait) state_nxt = HZ_DRAIN;
                end
                HZ_DRAIN: begin
                    if (ld_cnt_eff == '0) begin
                        ctl.issue = dec_valid_i;
                        state_nxt = HZ_RUN;
                    end else begin
                        ctl.stall = 1'b1;
                    end
                end
                HZ_FLUSH: begin
                    ctl.flush = 1'b1;
                    if (flush_cnt <= FCNT_W'(1)) state_nxt = HZ_RUN;
                end
                default: state_nxt = HZ_RUN;
            endcase
        end
    end

    assign issue_o = ctl.issue;
    assign stall_o = ctl.stall;
    assign flush_o = ctl.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HZ_RUN;
            flush_cnt <= '0;
            ld_cnt_o  <= '0;
            err_o     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ld_cnt_o <= ld_cnt_eff + CNT_W'(ctl.issue & dec_is_load_i);
            // the redirect cycle itself is the first flush cycle
            if (redirect_i) begin
                flush_cnt <= FCNT_W'(FLUSH_CYC - 1);
            end else if (state == HZ_FLUSH && flush_cnt != '0) begin
                flush_cnt <= flush_cnt - FCNT_W'(1);
            end
            if (ld_done_i && (ld_cnt_o == '0 || (ld_done_rd_i != '0 && !busy_o[ld_done_rd_i]))) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard-driven bench for hazard_ctrl; a second instance exercises a 3-cycle flush window.
module tb_hazard_ctrl;

    localparam logic [2:0] N = 3'b000;
    localparam logic [2:0] I = 3'b100;
    localparam logic [2:0] S = 3'b010;
    localparam logic [2:0] F = 3'b001;

    typedef struct packed {
        logic        rst;
        logic        v;
        logic [4:0]  r1;
        logic        u1;
        logic [4:0]  r2;
        logic        u2;
        logic [4:0]  rd;
        logic        ld;
        logic        fe;
        logic        dn;
        logic [4:0]  drd;
        logic        rdr;
        logic [2:0]  e1;
        logic [2:0]  e3;
        logic [31:0] busy;
        logic [2:0]  cnt;
        logic        err;
    } stim_t;

    typedef struct packed {
        logic [2:0]  e1;
        logic [2:0]  e3;
        logic [31:0] busy;
        logic [2:0]  cnt;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dec_valid = 1'b0, use1 = 1'b0, use2 = 1'b0, is_load = 1'b0, fence = 1'b0;
    logic        ld_done = 1'b0, redirect = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, ld_done_rd = '0;
    logic        issue1, stall1, flush1, err1, issue3, stall3, flush3, err3;
    logic [2:0]  cnt1, cnt3;
    logic [31:0] busy1, busy3;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    hazard_ctrl #(.MAX_LD(2), .FLUSH_CYC(1)) u_dut (
        .clk(clk), .rst(rst), .dec_valid_i(dec_valid), .dec_rs1_i(rs1), .dec_use_rs1_i(use1),
        .dec_rs2_i(rs2), .dec_use_rs2_i(use2), .dec_rd_i(rd), .dec_is_load_i(is_load),
        .dec_fence_i(fence), .ld_done_i(ld_done), .ld_done_rd_i(ld_done_rd), .redirect_i(redirect),
        .issue_o(issue1), .stall_o(stall1), .flush_o(flush1), .ld_cnt_o(cnt1), .busy_o(busy1),
        .err_o(err1)
    );

    hazard_ctrl #(.MAX_LD(2), .FLUSH_CYC(3)) u_dut3 (
        .clk(clk), .rst(rst), .dec_valid_i(dec_valid), .dec_rs1_i(rs1), .dec_use_rs1_i(use1),
        .dec_rs2_i(rs2), .dec_use_rs2_i(use2), .dec_rd_i(rd), .dec_is_load_i(is_load),
        .dec_fence_i(fence), .ld_done_i(ld_done), .ld_done_rd_i(ld_done_rd), .redirect_i(redirect),
        .issue_o(issue3), .stall_o(stall3), .flush_o(flush3), .ld_cnt_o(cnt3), .busy_o(busy3),
        .err_o(err3)
    );

    // drive one cycle of stimulus and queue what the DUT must show for it
    task automatic apply(input stim_t s);
        @(negedge clk);
        rst = s.rst; dec_valid = s.v; rs1 = s.r1; use1 = s.u1; rs2 = s.r2; use2 = s.u2;
        rd = s.rd; is_load = s.ld; fence = s.fe; ld_done = s.dn; ld_done_rd = s.drd;
        redirect = s.rdr;
        sb.push_back('{s.e1, s.e3, s.busy, s.cnt, s.err});
    endtask

    task automatic test_reset();
        stim_t rows [3];
        exp_t  e;
        rows = '{
            '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, N, 'h0, 0, 0},
            '{0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, I, I, 'h0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, N, 'h0, 0, 0}};
        for (int i = 0; i < 3; i++) begin
            apply(rows[i]);
            #1;
            e = sb.pop_front();
            checks++;
            if ({issue1, stall1, flush1, issue3, stall3, flush3, busy1, cnt1, err1, err3} !==
                {e.e1, e.e3, e.busy, e.cnt, e.err, e.err}) begin
                failures++;
                $display("FAIL reset[%0d] got ctl=%b/%b busy=%h cnt=%0d err=%b want ctl=%b/%b busy=%h cnt=%0d err=%b",
                         i, {issue1, stall1, flush1}, {issue3, stall3, flush3}, busy1, cnt1, err1,
                         e.e1, e.e3, e.busy, e.cnt, e.err);
            end
        end
    endtask

    task automatic test_raw();
        stim_t rows [11];
        exp_t  e;
        rows = '{
            '{0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, I, I, 'h0,   0, 0},
            '{0, 1, 5, 1, 1, 1, 6, 0, 0, 0, 0, 0, S, S, 'h20,  1, 0},
            '{0, 1, 5, 1, 1, 1, 6, 0, 0, 0, 0, 0, S, S, 'h20,  1, 0},
            '{0, 1, 5, 1, 1, 1, 6, 0, 0, 1, 5, 0, I, I, 'h20,  1, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, N, 'h0,   0, 0},
            '{0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, I, I, 'h0,   0, 0},
            '{0, 1, 9, 0, 3, 1, 4, 0, 0, 0, 0, 0, I, I, 'h200, 1, 0},
            '{0, 1, 1, 1, 9, 1, 4, 0, 0, 0, 0, 0, S, S, 'h200, 1, 0},
            '{0, 1, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, S, S, 'h200, 1, 0},
            '{0, 1, 0, 0, 0, 0, 9, 0, 0, 1, 9, 0, I, I, 'h200, 1, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, N, 'h0,   0, 0}};
        for (int i = 0; i < 11; i++) begin
            apply(rows[i]);
            #1;
            e = sb.pop_front();
            checks++;
            if ({issue1, stall1, flush1, issue3, stall3, flush3, busy1, cnt1, err1, err3} !==
                {e.e1, e.e3, e.busy, e.cnt, e.err, e.err}) begin
                failures++;
                $display("FAIL raw[%0d] got ctl=%b/%b busy=%h cnt=%0d err=%b want ctl=%b/%b busy=%h cnt=%0d err=%b",
                         i, {issue1, stall1, flush1}, {issue3, stall3, flush3}, busy1, cnt1, err1,
                         e.e1, e.e3, e.busy, e.cnt, e.err);
            end
        end
    endtask

    task automatic test_ld_full();
        stim_t rows [7];
        exp_t  e;
        rows = '{
            '{0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, I, I, 'h0,  0, 0},
            '{0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, I, I, 'h2,  1, 0},
            '{0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, S, S, 'h6,  2, 0},
            '{0, 1, 0, 0, 0, 0, 3, 1, 0, 1, 1, 0, I, I, 'h6,  2, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, N, N, 'hC,  2, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, N, N, 'h8,  1, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, N, 'h0,  0, 0}};
        for (int i = 0; i < 7; i++) begin
            apply(rows[i]);
            #1;
            e = sb.pop_front();
            checks++;
            if ({issue1, stall1, flush1, issue3, stall3, flush3, busy1, cnt1, err1, err3} !==
                {e.e1, e.e3, e.busy, e.cnt, e.err, e.err}) begin
                failures++;
                $display("FAIL ld_full[%0d] got ctl=%b/%b busy=%h cnt=%0d err=%b want ctl=%b/%b busy=%h cnt=%0d err=%b",
                         i, {issue1, stall1, flush1}, {issue3, stall3, flush3}, busy1, cnt1, err1,
                         e.e1, e.e3, e.busy, e.cnt, e.err);
            end
        end
    endtask

    task automatic test_fence();
        stim_t rows [8];
        exp_t  e;
        rows = '{
            '{0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, I, I, 'h0, 0, 0},
            '{0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, I, I, 'h2, 1, 0},
            '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, S, S, 'h6, 2, 0},
            '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, S, S, 'h6, 2, 0},
            '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, I, I, 'h4, 1, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, N, 'h0, 0, 0},
            '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, I, I, 'h0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, N, 'h0, 0, 0}};
        for (int i = 0; i < 8; i++) begin
            apply(rows[i]);
            #1;
            e = sb.pop_front();
            checks++;
            if ({issue1, stall1, flush1, issue3, stall3, flush3, busy1, cnt1, err1, err3} !==
                {e.e1, e.e3, e.busy, e.cnt, e.err, e.err}) begin
                failures++;
                $display("FAIL fence[%0d] got ctl=%b/%b busy=%h cnt=%0d err=%b want ctl=%b/%b busy=%h cnt=%0d err=%b",
                         i, {issue1, stall1, flush1}, {issue3, stall3, flush3}, busy1, cnt1, err1,
                         e.e1, e.e3, e.busy, e.cnt, e.err);
            end
        end
    endtask

    task automatic test_redirect();
        stim_t rows [13];
        exp_t  e;
        rows = '{
            '{0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, I, I, 'h0,  0, 0},
            '{0, 1, 5, 1, 0, 0, 6, 0, 0, 0, 0, 0, S, S, 'h20, 1, 0},
            '{0, 1, 5, 1, 0, 0, 6, 0, 0, 0, 0, 1, F, F, 'h20, 1, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, F, 'h20, 1, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, N, F, 'h20, 1, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, N, 'h0,  0, 0},
            '{0, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 1, F, F, 'h0,  0, 0},
            '{0, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, I, F, 'h0,  0, 0},
            '{0, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 1, F, F, 'h0,  0, 0},
            '{0, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, I, F, 'h0,  0, 0},
            '{0, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, I, F, 'h0,  0, 0},
            '{0, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, I, I, 'h0,  0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, N, 'h0,  0, 0}};
        for (int i = 0; i < 13; i++) begin
            apply(rows[i]);
            #1;
            e = sb.pop_front();
            checks++;
            if ({issue1, stall1, flush1, issue3, stall3, flush3, busy1, cnt1, err1, err3} !==
                {e.e1, e.e3, e.busy, e.cnt, e.err, e.err}) begin
                failures++;
                $display("FAIL redirect[%0d] got ctl=%b/%b busy=%h cnt=%0d err=%b want ctl=%b/%b busy=%h cnt=%0d err=%b",
                         i, {issue1, stall1, flush1}, {issue3, stall3, flush3}, busy1, cnt1, err1,
                         e.e1, e.e3, e.busy, e.cnt, e.err);
            end
        end
    endtask

    task automatic test_x0_err();
        stim_t rows [6];
        exp_t  e;
        rows = '{
            '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, I, I, 'h0, 0, 0},
            '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, I, I, 'h0, 1, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, N, N, 'h0, 1, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, N, N, 'h0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, N, 'h0, 0, 1},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, N, 'h0, 0, 1}};
        for (int i = 0; i < 6; i++) begin
            apply(rows[i]);
            #1;
            e = sb.pop_front();
            checks++;
            if ({issue1, stall1, flush1, issue3, stall3, flush3, busy1, cnt1, err1, err3} !==
                {e.e1, e.e3, e.busy, e.cnt, e.err, e.err}) begin
                failures++;
                $display("FAIL x0_err[%0d] got ctl=%b/%b busy=%h cnt=%0d err=%b want ctl=%b/%b busy=%h cnt=%0d err=%b",
                         i, {issue1, stall1, flush1}, {issue3, stall3, flush3}, busy1, cnt1, err1,
                         e.e1, e.e3, e.busy, e.cnt, e.err);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t rows [7];
        exp_t  e;
        rows = '{
            '{0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, I, I, 'h0,  0, 1},
            '{0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, I, I, 'h4,  1, 1},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, N, 'h24, 2, 1},
            '{1, 1, 0, 0, 0, 0, 7, 1, 0, 1, 2, 0, N, N, 'h24, 2, 1},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, N, 'h0,  0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, N, N, 'h0,  0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, N, 'h0,  0, 1}};
        for (int i = 0; i < 7; i++) begin
            apply(rows[i]);
            #1;
            e = sb.pop_front();
            checks++;
            if ({issue1, stall1, flush1, issue3, stall3, flush3, busy1, cnt1, err1, err3} !==
                {e.e1, e.e3, e.busy, e.cnt, e.err, e.err}) begin
                failures++;
                $display("FAIL reset_mid[%0d] got ctl=%b/%b busy=%h cnt=%0d err=%b want ctl=%b/%b busy=%h cnt=%0d err=%b",
                         i, {issue1, stall1, flush1}, {issue3, stall3, flush3}, busy1, cnt1, err1,
                         e.e1, e.e3, e.busy, e.cnt, e.err);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_raw();
        test_ld_full();
        test_fence();
        test_redirect();
        test_x0_err();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
